// File: rtl/run_ctrl_if.sv
// run_ctrl_if: board-pin/core-side signal bundle for the execution controller.
// Latency: none (wires only). Backpressure: none; all signals are levels.
// master = controller (samples debug inputs, drives core control and status);
// slave  = board/core side (drives debug inputs, observes control and status).
interface run_ctrl_if #(
  parameter int PC_W   = 16,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
) ();

  // Debug / core inputs to the controller
  logic                   is_halt;
  logic [PC_W-1:0]        pc;
  logic [1:0]             mode;
  logic                   step_req;
  logic                   resume_req;
  logic [NUM_BP-1:0]      bp_en;
  logic [NUM_BP*PC_W-1:0] bp_adr;

  // Core control and status outputs from the controller
  logic                   core_en;
  logic                   core_reset;
  logic                   halting;
  logic                   paused;
  logic [1:0]             stop_cause;
  logic [CNT_W-1:0]       cycles;
  logic                   cnt_ovf;

  modport master (
    input  is_halt, pc, mode, step_req, resume_req, bp_en, bp_adr,
    output core_en, core_reset, halting, paused, stop_cause, cycles, cnt_ovf
  );

  modport slave (
    output is_halt, pc, mode, step_req, resume_req, bp_en, bp_adr,
    input  core_en, core_reset, halting, paused, stop_cause, cycles, cnt_ovf
  );

endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run/pause/step/halt controller with PC breakpoints and a saturating commit counter.
// Latency: core_en is combinational from state/pc/breakpoints; all status outputs are registered.
// Backpressure: none; step/resume are level inputs turned into one-shot requests by edge detect.
// Ports: clk, reset_n (synchronous, active-low), bus (run_ctrl_if.master):
//   in : is_halt, pc, mode, step_req, resume_req, bp_en, bp_adr
//   out: core_en, core_reset, halting, paused, stop_cause, cycles, cnt_ovf
module run_ctrl #(
  parameter int PC_W   = 16,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  run_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HALT = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_BREAK = 2'd2;

  state_t           state_q,       state_d;
  logic [1:0]       stop_cause_q,  stop_cause_d;
  logic [CNT_W-1:0] cycles_q,      cycles_d;
  logic             cnt_ovf_q,     cnt_ovf_d;
  logic             step_prev_q,   step_prev_d;
  logic             resume_prev_q, resume_prev_d;
  logic             bp_skip_q,     bp_skip_d;
  logic             core_reset_q,  core_reset_d;
  logic             halting_q,     halting_d;
  logic             paused_q,      paused_d;

  logic bp_match;
  logic bp_hit;
  logic core_en;
  logic step_edge;
  logic resume_edge;

  // Any enabled comparator matching the current pc.
  always_comb begin
    bp_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bus.bp_en[i] && (bus.pc == bus.bp_adr[i*PC_W +: PC_W])) begin
        bp_match = 1'b1;
      end
    end
  end

  // bp_skip masks the trap for the one instruction we resume on, so a
  // breakpoint address can be executed after the user continues from it.
  assign bp_hit = (bus.mode == MODE_BREAK) && bp_match && !bp_skip_q;

  // A breakpoint hit suppresses commit in the same cycle; this is also why a
  // halt decoded at a breakpoint address is not taken.
  assign core_en = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);

  // prev registers clear on reset, but RST consumes no edges, so a level
  // already high at reset release never reaches PAUSE as a request.
  assign step_edge   = bus.step_req   && !step_prev_q;
  assign resume_edge = bus.resume_req && !resume_prev_q;

  // Next-state and stop-cause logic
  always_comb begin
    state_d      = state_q;
    stop_cause_d = stop_cause_q;
    bp_skip_d    = bp_skip_q;

    case (state_q)
      ST_RST: begin
        if (bus.mode == MODE_STEP) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (core_en) begin
          bp_skip_d = 1'b0;
        end
        if (core_en && bus.is_halt) begin
          state_d      = ST_HALT;
          stop_cause_d = CAUSE_HALT;
        end else if (bp_hit) begin
          state_d      = ST_PAUSE;
          stop_cause_d = CAUSE_BP;
        end else if (bus.mode == MODE_STEP) begin
          state_d      = ST_PAUSE;
          stop_cause_d = CAUSE_STEP;
        end
      end

      ST_PAUSE: begin
        // Step has priority; a simultaneous resume edge is simply dropped.
        if (step_edge) begin
          state_d = ST_STEP;
        end else if (resume_edge && (bus.mode != MODE_STEP)) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end
      end

      ST_STEP: begin
        if (bus.is_halt) begin
          state_d      = ST_HALT;
          stop_cause_d = CAUSE_HALT;
        end else begin
          state_d      = ST_PAUSE;
          stop_cause_d = CAUSE_STEP;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // Status flags are decoded from the next state so they come out of flops.
  always_comb begin
    core_reset_d = (state_d == ST_RST) || (state_d == ST_HALT);
    halting_d    = (state_d == ST_HALT);
    paused_d     = (state_d == ST_PAUSE);
  end

  // Commit counter: saturates at all-ones; a commit lost to saturation marks overflow.
  always_comb begin
    cycles_d  = cycles_q;
    cnt_ovf_d = cnt_ovf_q;
    if (core_en) begin
      if (&cycles_q) begin
        cnt_ovf_d = 1'b1;
      end else begin
        cycles_d = cycles_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    step_prev_d   = bus.step_req;
    resume_prev_d = bus.resume_req;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_RST;
      stop_cause_q  <= CAUSE_NONE;
      cycles_q      <= '0;
      cnt_ovf_q     <= 1'b0;
      step_prev_q   <= 1'b0;
      resume_prev_q <= 1'b0;
      bp_skip_q     <= 1'b0;
      core_reset_q  <= 1'b1;
      halting_q     <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      stop_cause_q  <= stop_cause_d;
      cycles_q      <= cycles_d;
      cnt_ovf_q     <= cnt_ovf_d;
      step_prev_q   <= step_prev_d;
      resume_prev_q <= resume_prev_d;
      bp_skip_q     <= bp_skip_d;
      core_reset_q  <= core_reset_d;
      halting_q     <= halting_d;
      paused_q      <= paused_d;
    end
  end

  assign bus.core_en    = core_en;
  assign bus.core_reset = core_reset_q;
  assign bus.halting    = halting_q;
  assign bus.paused     = paused_q;
  assign bus.stop_cause = stop_cause_q;
  assign bus.cycles     = cycles_q;
  assign bus.cnt_ovf    = cnt_ovf_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed stimulus for run_ctrl with a queued scoreboard.
// Stimulus pushes expected values tagged with the cycle they apply to; a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_run_ctrl;

  logic clk;
  logic rst_n;
  logic rst4_n;

  run_ctrl_if #(.PC_W(16), .CNT_W(32), .NUM_BP(2)) bus ();
  run_ctrl_if #(.PC_W(16), .CNT_W(4),  .NUM_BP(2)) bus4 ();

  run_ctrl #(.PC_W(16), .CNT_W(32), .NUM_BP(2)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  run_ctrl #(.PC_W(16), .CNT_W(4), .NUM_BP(2)) dut4 (
    .clk     (clk),
    .reset_n (rst4_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic auto_pc = 1'b0;

  localparam int S_EN = 0, S_CRST = 1, S_HALT = 2, S_PAUSE = 3, S_CAUSE = 4,
                 S_CYC = 5, S_OVF = 6, S_CYC4 = 7, S_OVF4 = 8, S_CRST4 = 9;

  function automatic logic [63:0] actual(int sel);
    case (sel)
      S_EN:    return 64'(bus.core_en);
      S_CRST:  return 64'(bus.core_reset);
      S_HALT:  return 64'(bus.halting);
      S_PAUSE: return 64'(bus.paused);
      S_CAUSE: return 64'(bus.stop_cause);
      S_CYC:   return 64'(bus.cycles);
      S_OVF:   return 64'(bus.cnt_ovf);
      S_CYC4:  return 64'(bus4.cycles);
      S_OVF4:  return 64'(bus4.cnt_ovf);
      S_CRST4: return 64'(bus4.core_reset);
      default: return '1;
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  exp_t        cur;
  logic [63:0] act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
      cur = sbq.pop_front();
      act = actual(cur.sel);
      n_cmp = n_cmp + 1;
      if (act !== cur.val) begin
        n_bad = n_bad + 1;
        $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", cur.name, cyc, act, cur.val);
      end
    end
  end

  task automatic chk(string nm, int sel, logic [63:0] v);
    exp_t e;
    e.tgt  = cyc;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  // One clock: inputs change #1 after the posedge; the core model advances pc
  // whenever the controller allowed a commit on that edge.
  task automatic tick(int n = 1);
    logic en_s;
    for (int k = 0; k < n; k++) begin
      en_s = bus.core_en;
      @(posedge clk);
      #1;
      if (auto_pc && en_s) bus.pc = bus.pc + 16'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    bus.pc = 16'd0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    rst4_n         = 1'b0;
    bus.is_halt    = 1'b0;
    bus.pc         = 16'd0;
    bus.mode       = 2'd0;
    bus.step_req   = 1'b0;
    bus.resume_req = 1'b0;
    bus.bp_en      = 2'b00;
    bus.bp_adr     = '0;
    bus4.is_halt    = 1'b0;
    bus4.pc         = 16'd0;
    bus4.mode       = 2'd0;
    bus4.step_req   = 1'b0;
    bus4.resume_req = 1'b0;
    bus4.bp_en      = 2'b00;
    bus4.bp_adr     = '0;
    auto_pc        = 1'b1;

    // ---- run from reset, halt on the 10th commit ----
    do_reset();
    chk("rst_core_reset", S_CRST, 1);
    chk("rst_core_en", S_EN, 0);
    chk("rst_halting", S_HALT, 0);
    chk("rst_paused", S_PAUSE, 0);
    chk("rst_cause", S_CAUSE, 0);
    chk("rst_cycles", S_CYC, 0);
    chk("rst_ovf", S_OVF, 0);
    tick();
    chk("run_core_en", S_EN, 1);
    chk("run_core_reset", S_CRST, 0);
    tick(9);
    chk("run_cycles9", S_CYC, 9);
    bus.is_halt = 1'b1;
    tick();
    bus.is_halt = 1'b0;
    chk("halt_halting", S_HALT, 1);
    chk("halt_cause", S_CAUSE, 1);
    chk("halt_cycles", S_CYC, 10);
    chk("halt_core_reset", S_CRST, 1);
    chk("halt_core_en", S_EN, 0);
    tick(3);
    chk("halt_sticky", S_HALT, 1);
    chk("halt_cycles_hold", S_CYC, 10);

    // ---- reset while halted ----
    rst_n = 1'b0;
    tick();
    chk("haltrst_core_reset", S_CRST, 1);
    chk("haltrst_halting", S_HALT, 0);
    chk("haltrst_cause", S_CAUSE, 0);
    chk("haltrst_cycles", S_CYC, 0);

    // ---- breakpoint at 4 (bp1 at 2 is disabled) ----
    bus.mode   = 2'd2;
    bus.bp_adr = {16'd2, 16'd4};
    bus.bp_en  = 2'b01;
    do_reset();
    tick();
    tick(4);
    chk("bp_core_en_at_hit", S_EN, 0);
    chk("bp_cycles_at_hit", S_CYC, 4);
    tick();
    chk("bp_paused", S_PAUSE, 1);
    chk("bp_cause", S_CAUSE, 2);
    chk("bp_core_en_pause", S_EN, 0);
    chk("bp_cycles_pause", S_CYC, 4);
    tick(2);
    chk("bp_still_paused", S_PAUSE, 1);
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    chk("resume_core_en", S_EN, 1);
    chk("resume_paused", S_PAUSE, 0);
    tick();
    chk("resume_cycles", S_CYC, 5);
    chk("resume_no_retrap", S_EN, 1);
    chk("resume_cause_kept", S_CAUSE, 2);
    // mode switch to STEP mid-RUN: this commit completes, then pause
    bus.mode = 2'd1;
    tick();
    chk("modechg_paused", S_PAUSE, 1);
    chk("modechg_cause", S_CAUSE, 3);
    chk("modechg_cycles", S_CYC, 6);

    // ---- step mode from reset ----
    bus.bp_en = 2'b00;
    bus.mode  = 2'd1;
    do_reset();
    tick();
    chk("step_init_paused", S_PAUSE, 1);
    chk("step_init_cause", S_CAUSE, 0);
    chk("step_init_core_en", S_EN, 0);
    for (int p = 1; p <= 3; p++) begin
      bus.step_req = 1'b1;
      tick();
      chk("step_pulse_en", S_EN, 1);
      tick();
      chk("step_back_paused", S_PAUSE, 1);
      chk("step_back_core_en", S_EN, 0);
      chk("step_cycles", S_CYC, 64'(p));
      chk("step_cause", S_CAUSE, 3);
      bus.step_req = 1'b0;
      tick();
    end
    bus.step_req = 1'b1;
    tick();
    chk("step_hold_en", S_EN, 1);
    tick(19);
    chk("step_hold_paused", S_PAUSE, 1);
    chk("step_hold_cycles", S_CYC, 4);
    bus.step_req = 1'b0;
    tick();

    // ---- step and resume edges together ----
    bus.mode       = 2'd0;
    bus.step_req   = 1'b1;
    bus.resume_req = 1'b1;
    tick();
    chk("both_step_en", S_EN, 1);
    tick();
    chk("both_paused", S_PAUSE, 1);
    chk("both_cycles", S_CYC, 5);
    tick(2);
    chk("both_stay_paused", S_PAUSE, 1);
    chk("both_cycles_hold", S_CYC, 5);
    bus.step_req   = 1'b0;
    bus.resume_req = 1'b0;
    tick();

    // ---- reset during STEP ----
    bus.step_req = 1'b1;
    tick();
    chk("midstep_en", S_EN, 1);
    rst_n = 1'b0;
    tick();
    chk("steprst_core_reset", S_CRST, 1);
    chk("steprst_halting", S_HALT, 0);
    chk("steprst_cause", S_CAUSE, 0);
    chk("steprst_paused", S_PAUSE, 0);
    chk("steprst_core_en", S_EN, 0);
    chk("steprst_cycles", S_CYC, 0);
    bus.step_req = 1'b0;

    // ---- 4-bit counter saturation ----
    rst4_n = 1'b1;
    tick();
    chk("sat_start", S_CYC4, 0);
    tick(20);
    chk("sat_cycles", S_CYC4, 15);
    chk("sat_ovf", S_OVF4, 1);
    rst4_n = 1'b0;
    tick();
    chk("sat_rst_cycles", S_CYC4, 0);
    chk("sat_rst_ovf", S_OVF4, 0);
    chk("sat_rst_core_reset", S_CRST4, 1);

    tick(2);
    if (sbq.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
